// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between a single-request core port
// and a word-wide synchronous data RAM without byte enables. Sub-word
// stores are done as read-modify-write. Responses are a one-cycle pulse.
//
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned halfword
// and word accesses with resp_err. When undefined, misaligned accesses are
// silently aligned (low offset bits ignored for the access size).
module lsu_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_CAP,
        ST_WR,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          f3_q, f3_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [1:0]          off_q, off_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                funct_ok;
    logic                misalign;
    logic                req_bad;

    // Address bits above the RAM range are dropped so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    // Sign/zero-extended load result picked from the lane given by the offset.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    load_extract = {{24{b[7]}}, b};
            3'd1:    load_extract = {{16{h[15]}}, h};
            3'd2:    load_extract = word;
            3'd4:    load_extract = {24'd0, b};
            3'd5:    load_extract = {16'd0, h};
            default: load_extract = '0;
        endcase
    endfunction

    // Old word with the addressed byte or halfword lane replaced by store data.
    function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] old_word,
                                                input logic [31:0] wd);
        logic [31:0] w;
        w = old_word;
        if (f3[1:0] == 2'b00) begin
            w[{off, 3'b000} +: 8] = wd[7:0];
        end else if (off[1]) begin
            w[31:16] = wd[15:0];
        end else begin
            w[15:0] = wd[15:0];
        end
        return w;
    endfunction

    // Classify the request on the pins: illegal funct3 or (optionally) misaligned.
    always_comb begin
        if (req_we) begin
            funct_ok = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2);
        end else begin
            funct_ok = (req_funct3 != 3'd3) && (req_funct3 != 3'd6) && (req_funct3 != 3'd7);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        req_bad = !funct_ok || misalign;
    end

    // Next-state, datapath next values and all handshake/memory outputs.
    always_comb begin
        // NOTE: every output and _d signal gets a default first so no path
        // through the case below leaves a value unassigned (no latches).
        state_d    = state_q;
        f3_d       = f3_q;
        waddr_d    = waddr_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;

        // NOTE: strobes are masked by reset so an abort cannot leak a RAM
        // write or a response in the cycle reset is first seen.
        case (state_q)
            IDLE: begin
                req_ready = !reset;
                if (req_valid) begin
                    f3_d    = req_funct3;
                    waddr_d = req_addr[ADDR_W+1:2];
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = req_bad;
                    if (req_bad) begin
                        state_d = RESP;
                    end else if (!req_we) begin
                        state_d = LD_RD;
                    end else if (req_funct3 == 3'd2) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LD_RD: begin
                mem_re  = !reset;
                state_d = LD_CAP;
            end
            LD_CAP: begin
                rdata_d = load_extract(f3_q, off_q, mem_rdata);
                state_d = RESP;
            end
            ST_WR: begin
                mem_we    = !reset;
                mem_wdata = wdata_q;
                state_d   = RESP;
            end
            RMW_RD: begin
                mem_re  = !reset;
                state_d = RMW_WR;
            end
            RMW_WR: begin
                mem_we    = !reset;
                mem_wdata = store_merge(f3_q, off_q, mem_rdata, wdata_q);
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = !reset;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request fields and the response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            f3_q    <= '0;
            waddr_q <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            f3_q    <= f3_d;
            waddr_q <= waddr_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr   = waddr_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural synchronous RAM model.
// Each request is driven at a falling edge and all DUT outputs are sampled
// on falling edges; cycle numbers are counted from the acceptance cycle T.
module tb_lsu_ctrl;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;

    // Results of the most recent run_req call.
    int                r_cyc;
    int                r_re_mask;
    int                r_we_mask;
    int                r_rdy_mask;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [ADDR_W-1:0] r_re_addr;
    logic [ADDR_W-1:0] r_we_addr;
    logic [31:0]       r_we_data;
    bit                r_clash;

    logic              ram_load;
    logic [31:0]       ram [0:(1<<ADDR_W)-1];

    lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data valid the cycle after mem_re.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= 32'h0;
            ram[0] <= 32'h8899AABB;
            ram[1] <= 32'h11223344;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= ram[mem_addr];
        end
    end

    always @(posedge clk) begin
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one request (caller sits at a falling edge in IDLE) and record
    // per-cycle activity up to the response; returns at the falling edge of
    // the cycle after the response.
    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input bit hold);
        int wait_cnt;
        r_cyc = -1; r_re_mask = 0; r_we_mask = 0; r_rdy_mask = 0;
        r_rdata = '0; r_err = 1'b0; r_re_addr = '0; r_we_addr = '0;
        r_we_data = '0; r_clash = 1'b0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        wait_cnt = 0;
        while (!req_ready && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!req_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: req_ready got %b required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_re) begin
                r_re_mask |= (1 << c);
                r_re_addr = mem_addr;
            end
            if (mem_we) begin
                if (r_we_mask == 0) begin
                    r_we_addr = mem_addr;
                    r_we_data = mem_wdata;
                end
                r_we_mask |= (1 << c);
            end
            if (mem_re && mem_we) r_clash = 1'b1;
            if (req_ready) r_rdy_mask |= (1 << c);
            if (resp_valid) begin
                r_cyc   = c;
                r_rdata = resp_rdata;
                r_err   = resp_err;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b required 0", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b required 0", resp_valid); end
        n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err: got %b required 0", resp_err); end
        n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_resp_rdata: got %h required 0", resp_rdata); end
        n_checks++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL rst_mem_re: got %b required 0", mem_re); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b required 0", mem_we); end
        n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_mem_addr: got %h required 0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h required 0", mem_wdata); end
        reset = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b required 1", req_ready); end
        @(negedge clk);
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] exp;
    } ld_vec_t;

    task automatic test_load();
        ld_vec_t v [0:7];
        logic [ADDR_W-1:0] wa;
        v[0] = '{32'h1,    3'd0, 32'hFFFFFFAA};
        v[1] = '{32'h3,    3'd4, 32'h00000088};
        v[2] = '{32'h0,    3'd0, 32'hFFFFFFBB};
        v[3] = '{32'h2,    3'd1, 32'hFFFF8899};
        v[4] = '{32'h0,    3'd5, 32'h0000AABB};
        v[5] = '{32'h0,    3'd2, 32'h8899AABB};
        v[6] = '{32'h4,    3'd4, 32'h00000044};
        v[7] = '{32'h1004, 3'd2, 32'h11223344};
        for (int i = 0; i < 8; i++) begin
            wa = v[i].addr[ADDR_W+1:2];
            run_req(1'b0, v[i].f3, v[i].addr, 32'h0, 1'b0);
            n_checks++; if (r_cyc !== 3) begin n_fail++; $display("FAIL load[%0d] resp_cycle: got %0d required 3", i, r_cyc); end
            n_checks++; if (r_rdata !== v[i].exp) begin n_fail++; $display("FAIL load[%0d] rdata: got %h required %h", i, r_rdata, v[i].exp); end
            n_checks++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL load[%0d] err: got %b required 0", i, r_err); end
            n_checks++; if (r_re_mask !== 2 || r_we_mask !== 0) begin n_fail++; $display("FAIL load[%0d] strobes: got re %h we %h required re 2 we 0", i, r_re_mask, r_we_mask); end
            n_checks++; if (r_re_addr !== wa) begin n_fail++; $display("FAIL load[%0d] mem_addr: got %h required %h", i, r_re_addr, wa); end
        end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_after_resp: got %b required 1", req_ready); end
    endtask

    task automatic test_store_sub();
        logic [31:0] sa [0:2];
        logic [2:0]  sf [0:2];
        logic [31:0] sd [0:2];
        logic [31:0] se [0:2];
        logic [ADDR_W-1:0] wa;
        sa[0] = 32'h6; sf[0] = 3'd0; sd[0] = 32'h000000EE; se[0] = 32'h11EE3344;
        sa[1] = 32'h4; sf[1] = 3'd1; sd[1] = 32'h1234CAFE; se[1] = 32'h11EECAFE;
        sa[2] = 32'hF; sf[2] = 3'd0; sd[2] = 32'hFFFFFF5A; se[2] = 32'h5A000000;
        for (int i = 0; i < 3; i++) begin
            wa = sa[i][ADDR_W+1:2];
            run_req(1'b1, sf[i], sa[i], sd[i], 1'b0);
            n_checks++; if (r_cyc !== 3 || r_err !== 1'b0 || r_rdata !== 32'h0) begin n_fail++; $display("FAIL rmw[%0d] resp: got cyc %0d err %b rdata %h required 3 0 0", i, r_cyc, r_err, r_rdata); end
            n_checks++; if (r_re_mask !== 2 || r_we_mask !== 4 || r_clash) begin n_fail++; $display("FAIL rmw[%0d] strobes: got re %h we %h clash %b required 2 4 0", i, r_re_mask, r_we_mask, r_clash); end
            n_checks++; if (r_we_addr !== wa) begin n_fail++; $display("FAIL rmw[%0d] mem_addr: got %h required %h", i, r_we_addr, wa); end
            n_checks++; if (r_we_data !== se[i]) begin n_fail++; $display("FAIL rmw[%0d] mem_wdata: got %h required %h", i, r_we_data, se[i]); end
            n_checks++; if (ram[wa] !== se[i]) begin n_fail++; $display("FAIL rmw[%0d] ram: got %h required %h", i, ram[wa], se[i]); end
        end
    endtask

    task automatic test_store_word();
        run_req(1'b1, 3'd2, 32'h8, 32'hDEADBEEF, 1'b0);
        n_checks++; if (r_cyc !== 2 || r_err !== 1'b0 || r_rdata !== 32'h0) begin n_fail++; $display("FAIL sw resp: got cyc %0d err %b rdata %h required 2 0 0", r_cyc, r_err, r_rdata); end
        n_checks++; if (r_re_mask !== 0 || r_we_mask !== 2) begin n_fail++; $display("FAIL sw strobes: got re %h we %h required 0 2", r_re_mask, r_we_mask); end
        n_checks++; if (r_we_addr !== 10'd2 || r_we_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw write: got addr %h data %h required 2 deadbeef", r_we_addr, r_we_data); end
        run_req(1'b0, 3'd1, 32'hA, 32'h0, 1'b0);
        n_checks++; if (r_cyc !== 3 || r_rdata !== 32'hFFFFDEAD) begin n_fail++; $display("FAIL sw_lh readback: got cyc %0d rdata %h required 3 ffffdead", r_cyc, r_rdata); end
    endtask

    task automatic test_illegal();
        logic        iw [0:2];
        logic [2:0]  ifn [0:2];
        iw[0] = 1'b0; ifn[0] = 3'd3;
        iw[1] = 1'b1; ifn[1] = 3'd4;
        iw[2] = 1'b0; ifn[2] = 3'd7;
        for (int i = 0; i < 3; i++) begin
            run_req(iw[i], ifn[i], 32'h4, 32'hFFFFFFFF, 1'b0);
            n_checks++; if (r_cyc !== 1 || r_err !== 1'b1 || r_rdata !== 32'h0) begin n_fail++; $display("FAIL illegal[%0d] resp: got cyc %0d err %b rdata %h required 1 1 0", i, r_cyc, r_err, r_rdata); end
            n_checks++; if (r_re_mask !== 0 || r_we_mask !== 0) begin n_fail++; $display("FAIL illegal[%0d] strobes: got re %h we %h required 0 0", i, r_re_mask, r_we_mask); end
        end
        run_req(1'b0, 3'd2, 32'h2, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        n_checks++; if (r_cyc !== 1 || r_err !== 1'b1 || r_rdata !== 32'h0 || r_re_mask !== 0) begin n_fail++; $display("FAIL lw_misalign: got cyc %0d err %b rdata %h re %h required 1 1 0 0", r_cyc, r_err, r_rdata, r_re_mask); end
`else
        n_checks++; if (r_cyc !== 3 || r_err !== 1'b0 || r_rdata !== 32'h8899AABB) begin n_fail++; $display("FAIL lw_misalign: got cyc %0d err %b rdata %h required 3 0 8899aabb", r_cyc, r_err, r_rdata); end
`endif
        run_req(1'b0, 3'd1, 32'h3, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        n_checks++; if (r_cyc !== 1 || r_err !== 1'b1 || r_re_mask !== 0) begin n_fail++; $display("FAIL lh_misalign: got cyc %0d err %b re %h required 1 1 0", r_cyc, r_err, r_re_mask); end
`else
        n_checks++; if (r_cyc !== 3 || r_err !== 1'b0 || r_rdata !== 32'hFFFF8899) begin n_fail++; $display("FAIL lh_misalign: got cyc %0d err %b rdata %h required 3 0 ffff8899", r_cyc, r_err, r_rdata); end
`endif
    endtask

    task automatic test_reset_abort();
        bit we_seen;
        bit rv_seen;
        we_seen = 1'b0;
        rv_seen = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h8; req_wdata = 32'h00001234;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        if (mem_we) we_seen = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_we !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_t2: got we %b resp_valid %b required 0 0", mem_we, resp_valid); end
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready_in_reset: got %b required 0", req_ready); end
        reset = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready_release: got %b required 1", req_ready); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_we) we_seen = 1'b1;
            if (resp_valid) rv_seen = 1'b1;
        end
        n_checks++; if (we_seen || rv_seen) begin n_fail++; $display("FAIL abort_activity: got we %b resp %b required 0 0", we_seen, rv_seen); end
        n_checks++; if (ram[2] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL abort_ram: got %h required deadbeef", ram[2]); end
    endtask

    task automatic test_back_to_back();
        int acc0;
        acc0 = acc_cnt;
        run_req(1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
        n_checks++; if (r_cyc !== 3 || r_rdata !== 32'h8899AABB || r_rdy_mask !== 0) begin n_fail++; $display("FAIL b2b_lw0: got cyc %0d rdata %h rdy %h required 3 8899aabb 0", r_cyc, r_rdata, r_rdy_mask); end
        run_req(1'b1, 3'd2, 32'hC, 32'h00000055, 1'b1);
        n_checks++; if (r_cyc !== 2 || r_we_mask !== 2 || r_rdy_mask !== 0) begin n_fail++; $display("FAIL b2b_sw: got cyc %0d we %h rdy %h required 2 2 0", r_cyc, r_we_mask, r_rdy_mask); end
        run_req(1'b0, 3'd2, 32'hC, 32'h0, 1'b0);
        n_checks++; if (r_cyc !== 3 || r_rdata !== 32'h00000055 || r_rdy_mask !== 0) begin n_fail++; $display("FAIL b2b_lw3: got cyc %0d rdata %h rdy %h required 3 00000055 0", r_cyc, r_rdata, r_rdy_mask); end
        repeat (3) @(negedge clk);
        n_checks++; if (acc_cnt - acc0 !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d required 3", acc_cnt - acc0); end
    endtask

    initial begin
        reset      = 1'b1;
        ram_load   = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        ram_load = 1'b0;
        test_reset();
        test_load();
        test_store_sub();
        test_store_word();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
